pipeline_hazard_ctrl: RTL and testbench

Hazard and flow-control unit that drives the stall, flush and forwarding controls for the five-stage vector pipeline: the `clr` input of the decode/execute register, the enables of the fetch/decode and later stage registers, and the execute-stage operand forwarding muxes. It detects load-use and branch hazards combinationally. It also runs a small state machine that holds the pipeline while a vector memory access in the M stage waits for `mem_ready`, with a timeout that latches an error.

---
 rtl/pipeline_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard, stall/flush and forwarding control for the five-stage vector pipeline.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       RA1D,
    input  logic [2:0]       RA2D,
    input  logic [2:0]       RA1E,
    input  logic [2:0]       RA2E,
    input  logic [2:0]       WA3E,
    input  logic [2:0]       WA3M,
    input  logic [2:0]       WA3W,
    input  logic             MemtoRegE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             BranchTakenE,
    input  logic             MemReqM,
    input  logic             mem_ready,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_error_q, mem_error_d;
    logic              ld_stall;
    logic              mem_stall;

    // Execute-stage operand forwarding; M has priority over W.
    always_comb begin
        ForwardAE = 2'b00;
        if (RegWriteM && (WA3M == RA1E)) begin
            ForwardAE = 2'b10;
        end else if (RegWriteW && (WA3W == RA1E)) begin
            ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RegWriteM && (WA3M == RA2E)) begin
            ForwardBE = 2'b10;
        end else if (RegWriteW && (WA3W == RA2E)) begin
            ForwardBE = 2'b01;
        end
    end

    assign ld_stall  = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    assign mem_stall = ((state_q == IDLE) || (state_q == MEM_WAIT)) && MemReqM && !mem_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    // Next state and wait counter; ERROR only leaves through reset.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        if (mem_stall) begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
        case (state_q)
            IDLE: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_stall && (wait_cnt_q == WCNT_W'(MEM_TIMEOUT - 1))) begin
                    state_d = ERROR;
                end else if (!mem_stall) begin
                    state_d = IDLE;
                end
            end
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
        endcase
        mem_error_d = (state_d == ERROR);
    end

    // Mealy stall/flush outputs in priority order.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (state_q == ERROR) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (BranchTakenE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (ld_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign mem_error = mem_error_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    // Saturating event counters.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (StallF && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (FlushE && !(&flush_count_q)) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MEM_TIMEOUT = 4).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 32;

    logic clk = 1'b0;
    logic reset;
    logic [2:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic MemtoRegE, RegWriteM, RegWriteW, BranchTakenE, MemReqM, mem_ready;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_error;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic [6:0] ctrl;
    logic [CNT_W-1:0] sc_before;

    int n_cmp = 0;
    int n_err = 0;

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    localparam logic [6:0] C_NONE   = 7'b0000000;
    localparam logic [6:0] C_LDUSE  = 7'b1100010;
    localparam logic [6:0] C_BRANCH = 7'b0000110;
    localparam logic [6:0] C_MEMWT  = 7'b1111001;
    localparam logic [6:0] C_ERROR  = 7'b1111000;

    assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .mem_ready(mem_ready),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .mem_error(mem_error), .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RA1D = 3'd0; RA2D = 3'd0; RA1E = 3'd0; RA2E = 3'd0;
        WA3E = 3'd7; WA3M = 3'd7; WA3W = 3'd7;
        MemtoRegE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        BranchTakenE = 1'b0; MemReqM = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        clear_inputs();
        #3;
        check_eq("rst_ctrl", 32'(ctrl), 32'(C_NONE));
        check_eq("rst_err", 32'(mem_error), 32'd0);
        check_eq("rst_fwd", 32'({ForwardAE, ForwardBE}), 32'd0);
        check_eq("rst_sc", stall_cycles, 32'd0);
        check_eq("rst_fc", flush_count, 32'd0);
        #9 reset = 1'b1;
        cyc();

        // Load-use via RA1D: one bubble, released when the load leaves E.
        MemtoRegE = 1'b1; WA3E = 3'd3; RA1D = 3'd3; #1;
        check_eq("ld_ra1", 32'(ctrl), 32'(C_LDUSE));
        cyc();
        MemtoRegE = 1'b0; #1;
        check_eq("ld_release", 32'(ctrl), 32'(C_NONE));
        MemtoRegE = 1'b1; RA1D = 3'd0; RA2D = 3'd3; #1;
        check_eq("ld_ra2", 32'(ctrl), 32'(C_LDUSE));
        WA3E = 3'd4; #1;
        check_eq("ld_nomatch", 32'(ctrl), 32'(C_NONE));
        cyc();
        clear_inputs();

        // Forwarding.
        RegWriteM = 1'b1; WA3M = 3'd2; RegWriteW = 1'b1; WA3W = 3'd2;
        RA1E = 3'd2; RA2E = 3'd5; #1;
        check_eq("fwd_a_m", 32'(ForwardAE), 32'd2);
        check_eq("fwd_b_rf", 32'(ForwardBE), 32'd0);
        RegWriteM = 1'b0; #1;
        check_eq("fwd_a_w", 32'(ForwardAE), 32'd1);
        RegWriteM = 1'b1; WA3M = 3'd0; RA2E = 3'd0; WA3W = 3'd5; #1;
        check_eq("fwd_b_r0", 32'(ForwardBE), 32'd2);
        clear_inputs();

        // Branch beats load-use.
        BranchTakenE = 1'b1; MemtoRegE = 1'b1; WA3E = 3'd3; RA1D = 3'd3; #1;
        check_eq("br_over_ld", 32'(ctrl), 32'(C_BRANCH));
        cyc();
        clear_inputs();
        cyc();

        // Memory wait of 3 cycles.
        sc_before = stall_cycles;
        MemReqM = 1'b1; mem_ready = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("memwt_%0d", i), 32'(ctrl), 32'(C_MEMWT));
            cyc();
        end
        mem_ready = 1'b1; #1;
        check_eq("memwt_release", 32'(ctrl), 32'(C_NONE));
        cyc();
`ifdef HAZARD_PERF_EN
        check_eq("memwt_sc", stall_cycles - sc_before, 32'd3);
`else
        check_eq("memwt_sc", stall_cycles, 32'd0);
`endif
        // Ready already high at entry: no stall; then branch deferred under a wait.
        check_eq("mem_ready_hit", 32'(ctrl), 32'(C_NONE));
        mem_ready = 1'b0; BranchTakenE = 1'b1; #1;
        check_eq("br_deferred", 32'(ctrl), 32'(C_MEMWT));
        cyc();
        mem_ready = 1'b1; #1;
        check_eq("br_after_wait", 32'(ctrl), 32'(C_BRANCH));
        cyc();
        clear_inputs();
        cyc();

        // Timeout after 4 wait cycles.
        MemReqM = 1'b1; mem_ready = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("to_err_%0d", i), 32'(mem_error), 32'd0);
            cyc();
        end
        check_eq("to_err_set", 32'(mem_error), 32'd1);
        check_eq("to_ctrl", 32'(ctrl), 32'(C_ERROR));
        MemReqM = 1'b0; cyc();
        check_eq("to_sticky", 32'(mem_error), 32'd1);
        check_eq("to_hold", 32'(ctrl), 32'(C_ERROR));
        reset = 1'b0; #1;
        check_eq("to_rst_err", 32'(mem_error), 32'd0);
        check_eq("to_rst_ctrl", 32'(ctrl), 32'(C_NONE));
        #1 reset = 1'b1;
        cyc();

        // Reset in cycle 2 of a wait restarts the full timeout.
        MemReqM = 1'b1; mem_ready = 1'b0;
        cyc();
        reset = 1'b0; #1;
        check_eq("mid_rst_ctrl", 32'(ctrl), 32'(C_MEMWT));
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("mid_err_%0d", i), 32'(mem_error), 32'd0);
            cyc();
        end
        check_eq("mid_err_set", 32'(mem_error), 32'd1);

        clear_inputs();
        reset = 1'b0;
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
